// File: rtl/ah_rr_grant_mux_pkg.sv
// ah_arb_pkg: definitions shared by the round-robin arbiter slice.
//   state_t     - ownership FSM states (IDLE, OWN)
//   clog2_min1  - ceil(log2(n)), never less than 1, so a width is always legal
//   *_DEF       - default client count, payload width, beat limit and the
//                 index/counter widths derived from them
package ah_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int NUM_CLIENTS_DEF = 4;
  localparam int DATA_W_DEF      = 32;
  localparam int MAX_BEATS_DEF   = 16;
  localparam int SRC_W_DEF       = clog2_min1(NUM_CLIENTS_DEF);
  localparam int CNT_W_DEF       = clog2_min1(MAX_BEATS_DEF);

endpackage

// File: rtl/ah_rr_grant_mux_if.sv
// ah_rr_grant_mux_if: master-side beat stream of the grant mux.
//   m_valid / m_ready - valid/ready handshake
//   m_data            - payload beat
//   m_last            - final beat of an ownership
//   m_src             - index of the client that sourced m_data
// Modports: master (the mux drives the beat), slave (downstream sink).
interface ah_rr_grant_mux_if
  import ah_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SRC_W  = SRC_W_DEF
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [SRC_W-1:0]  m_src;

  modport master (output m_valid, m_data, m_last, m_src, input m_ready);
  modport slave  (input m_valid, m_data, m_last, m_src, output m_ready);

endinterface

// File: rtl/ah_rr_grant_mux_enc.sv
// ah_onehot_enc: one-hot to binary encoder.
//   vec       in  N  grant vector
//   idx       out W  index of the lowest set bit (0 when none set)
//   any       out 1  at least one bit set
//   multi_hot out 1  more than one bit set
module ah_onehot_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi_hot
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign any       = |vec;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(vec & (vec - N'(1)));

endmodule

// File: rtl/ah_rr_grant_mux.sv
// ah_rr_grant_mux: downstream stage of the 4-client round-robin arbiter.
// Latches the granted client as burst owner, forwards its beats through one
// output register to the master port, and masks requests to the arbiter
// while a burst is in flight.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cli_req  -> req_out           raw requests in, masked requests to arbiter
//   gnt_in                        one-hot grant from the arbiter
//   cli_valid/cli_data/cli_last   per-client beat inputs, cli_ready accepts
//   m (ah_rr_grant_mux_if.master) master beat stream
//   busy                          high while a client owns the port
//   gnt_err                       one-cycle pulse on an illegal grant
//   timeout                       one-cycle pulse on watchdog release
// Optional feature macro: AH_GRANT_MUX_TIMEOUT_EN enables the idle-owner
// watchdog; without it timeout is tied 0 and an owner may idle forever.
module ah_rr_grant_mux
  import ah_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_BEATS   = MAX_BEATS_DEF,
  parameter int TIMEOUT_CYC = 64,
  localparam int SRC_W      = clog2_min1(NUM_CLIENTS),
  localparam int CNT_W      = clog2_min1(MAX_BEATS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cli_req,
  output logic [NUM_CLIENTS-1:0]        req_out,
  input  logic [NUM_CLIENTS-1:0]        gnt_in,
  input  logic [NUM_CLIENTS-1:0]        cli_valid,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]        cli_last,
  output logic [NUM_CLIENTS-1:0]        cli_ready,
  ah_rr_grant_mux_if.master             m,
  output logic                          busy,
  output logic                          gnt_err,
  output logic                          timeout
);

  state_t            state;
  logic [SRC_W-1:0]  owner;
  logic [CNT_W-1:0]  beat_cnt;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic              gnt_multi;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;
  logic              reg_free;
  logic              accept;
  logic              force_last;
  logic              burst_end;
  logic              to_fire;

  ah_onehot_enc #(.N(NUM_CLIENTS), .W(SRC_W)) u_gnt_enc (
    .vec       (gnt_in),
    .idx       (gnt_idx),
    .any       (gnt_any),
    .multi_hot (gnt_multi)
  );

  assign own_valid = cli_valid[owner];
  assign own_last  = cli_last[owner];

  always_comb begin
    own_data = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (owner == SRC_W'(i)) own_data = cli_data[i*DATA_W +: DATA_W];
    end
  end

  // The output register can take a beat when empty or draining this cycle,
  // which gives one beat per cycle under continuous m_ready.
  assign reg_free   = !m.m_valid || m.m_ready;
  assign accept     = (state == OWN) && own_valid && reg_free;
  assign force_last = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign burst_end  = accept && (own_last || force_last);

  assign req_out = (state == OWN) ? '0 : cli_req;

  always_comb begin
    cli_ready = '0;
    if (state == OWN && reg_free) cli_ready[owner] = 1'b1;
  end

  // Ownership FSM. A grant seen while OWN is a protocol error from the
  // arbiter and never changes the owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      gnt_err  <= 1'b0;
    end else begin
      gnt_err <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner    <= gnt_idx;
            beat_cnt <= '0;
            state    <= OWN;
            busy     <= 1'b1;
            gnt_err  <= gnt_multi;
          end
        end
        OWN: begin
          gnt_err <= gnt_any;
          if (burst_end || to_fire) begin
            state    <= IDLE;
            busy     <= 1'b0;
            beat_cnt <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register; it keeps its contents while stalled and may still hold
  // the previous owner's final beat after the FSM has returned to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.m_valid <= 1'b0;
      m.m_data  <= '0;
      m.m_last  <= 1'b0;
      m.m_src   <= '0;
    end else if (accept) begin
      m.m_valid <= 1'b1;
      m.m_data  <= own_data;
      m.m_last  <= own_last || force_last;
      m.m_src   <= owner;
    end else if (m.m_ready) begin
      m.m_valid <= 1'b0;
    end
  end

`ifdef AH_GRANT_MUX_TIMEOUT_EN
  localparam int TO_W = clog2_min1(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt;

  // Fires on the TIMEOUT_CYC-th consecutive idle cycle; the release never
  // coincides with an accept because the owner is not presenting a beat.
  assign to_fire = (state == OWN) && !own_valid &&
                   (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Idle-owner watchdog: counts owner cycles without a valid beat and
  // restarts whenever a beat is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_fire;
      if (state != OWN || accept || to_fire) begin
        idle_cnt <= '0;
      end else if (!own_valid) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end
    end
  end
`else
  logic unused_timeout_cfg;

  // The watchdog limit has no consumer when the watchdog is absent.
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign to_fire            = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: doc/ah_rr_grant_mux.md
Name: ah_rr_grant_mux

Overview:
- Downstream stage of the 4-client round-robin arbiter.
- Takes the arbiter's registered one-hot grant and latches the winning client as burst owner.
- Forwards that client's payload beats to a single master port over valid/ready, with one output register stage.
- Masks all requests back to the arbiter while a burst is in flight, so no new grant is issued mid-burst.

Parameters:
- NUM_CLIENTS, 4, number of requesters; must match the arbiter width.
- DATA_W, 32, payload width per beat.
- MAX_BEATS, 16, maximum beats per ownership; the block forces last at this count.
- TIMEOUT_CYC, 64, idle-owner watchdog limit in cycles; used only with the optional feature.
- SRC_W, localparam = clog2(NUM_CLIENTS).
- CNT_W, localparam = clog2(MAX_BEATS).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cli_req  in  NUM_CLIENTS  raw client requests
- req_out  out  NUM_CLIENTS  masked requests, to the arbiter's req
- gnt_in  in  NUM_CLIENTS  one-hot grant, from the arbiter's gnt
- cli_valid  in  NUM_CLIENTS  per-client beat valid
- cli_data  in  NUM_CLIENTS*DATA_W  packed payloads; client i occupies [i*DATA_W +: DATA_W]
- cli_last  in  NUM_CLIENTS  per-client last-beat marker
- cli_ready  out  NUM_CLIENTS  per-client beat accept
- m_valid  out  1  master beat valid
- m_data  out  DATA_W  master payload
- m_last  out  1  master last beat
- m_src  out  SRC_W  index of the client that sourced the current m_data
- m_ready  in  1  master accept
- busy  out  1  high while in OWN
- gnt_err  out  1  one-cycle pulse on an illegal grant
- timeout  out  1  one-cycle pulse on watchdog release; tied 0 without the macro

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE; owner = 0; beat_cnt = 0.

FSM IDLE:
- req_out = cli_req.
- Any gnt_in bit set: latch owner = encoded grant, clear beat_cnt, go to OWN next cycle.
- Multi-hot gnt_in: take the lowest set index and pulse gnt_err.

FSM OWN:
- req_out = 0 and busy = 1.
- A gnt_in pulse while in OWN is ignored and pulses gnt_err.

Handshake and data path:
- Beat accept = cli_valid[owner] & cli_ready[owner].
- cli_ready[owner] = OWN & (!m_valid | m_ready); all other cli_ready bits are 0.
- An accepted beat loads m_data, m_src, m_last and sets m_valid on the next edge. Latency is one cycle.
- m_valid clears when m_ready=1 and no new beat is accepted in the same cycle.
- m_valid, m_data and m_last hold steady while m_ready=0.
- Simultaneous drain and accept: full throughput, one beat per cycle.

Burst end:
- beat_cnt increments on each accept.
- Burst ends on an accepted beat with cli_last=1, or on the accept where beat_cnt == MAX_BEATS-1. The forced case drives m_last=1 regardless of cli_last.
- On burst end: go to IDLE and clear beat_cnt.
- The output register may still hold the final beat while in IDLE. The next owner's first beat may enter as soon as the register frees.

Boundaries and reset:
- cli_valid low in OWN: wait indefinitely (watchdog aside).
- beat_cnt never wraps.
- Async reset mid-burst: the in-flight beat is dropped, m_valid=0, FSM goes to IDLE.
- The arbiter's alternate-cycle grant toggling has no effect beyond the first grant cycle.

Optional Feature:
- Macro: AH_GRANT_MUX_TIMEOUT_EN.
- Defined: in OWN, a counter increments on cycles with cli_valid[owner]=0 and clears on any accept.
- When the counter reaches TIMEOUT_CYC, the block pulses timeout, returns to IDLE and emits no beat. m_last is not synthesised for the truncated burst.
- Undefined: the counter logic is absent, the timeout port is tied 0, and OWN waits indefinitely.

Decomposition:
- Shared package ah_arb_pkg holds:
  - state enum {IDLE, OWN}
  - the clog2-derived width constants
  - default NUM_CLIENTS and DATA_W
- Sub-module ah_onehot_enc: one-hot to binary encoder with lowest-index priority and a multi_hot flag output. It is reused for both the owner latch and gnt_err.

Test Plan:
- Single burst: client 2 wins (gnt_in=4'b0100), sends 3 beats A,B,C with last on C, m_ready=1 → m_data A,B,C on consecutive cycles, m_src=2, m_last only on C, req_out=0 during the burst, then IDLE.
- Backpressure: m_ready=0 for 4 cycles mid-burst → m_data held stable, cli_ready[owner]=0, no beat lost or duplicated, order preserved.
- Forced truncation: client 0 streams 20 beats with cli_last=0, MAX_BEATS=16 → m_last=1 on beat 16, FSM returns to IDLE, req_out re-opens the next cycle.
- Illegal grant: gnt_in=4'b1010 in IDLE → owner=1, one gnt_err pulse; a gnt_in pulse during OWN → a second gnt_err pulse, owner unchanged.
- Reset mid-burst: assert rst_n=0 after beat 2 of 5 → m_valid=0 immediately, busy=0, cli_ready=0, clean new burst after release.
- With AH_GRANT_MUX_TIMEOUT_EN and TIMEOUT_CYC=8: owner 3 holds cli_valid=0 for 8 cycles → one timeout pulse, FSM in IDLE, no m_valid.
